// File: rtl/jtag_ir_dr_mux.sv
// -----------------------------------------------------------------------------
// jtag_ir_dr_mux
//
// JTAG instruction register and TDO path. Holds the IR shift and update
// registers, the BYPASS register and a channel decoder that selects one of
// NUM_CH external data registers. TDO and its output enable are retimed on the
// falling edge of TCK.
//
// Parameters
//   IR_BITS      instruction register width (at least 2)
//   NUM_CH       number of external data-register channels
//   CH_CODES     flat code table; channel i code at [i*IR_BITS +: IR_BITS]
//   RESET_INSTR  instruction selected after reset / Test-Logic-Reset
//
// Ports
//   TCK, TRST          test clock, asynchronous active-low reset
//   TDI                serial data in
//   Test_Logic_Reset,
//   Capture_IR, Shift_IR, Update_IR,
//   Capture_DR, Shift_DR  TAP controller state strobes
//   dr_shift_in        TDO-side bit of each external data register
//   instr_out          current instruction
//   dr_sel             one-hot selected channel (zero when BYPASS selected)
//   bypass_sel         BYPASS register selected
//   TDO, tdo_en        test data out and its enable
// -----------------------------------------------------------------------------
module jtag_ir_dr_mux #(
    parameter int                         IR_BITS     = 5,
    parameter int                         NUM_CH      = 4,
    parameter logic [NUM_CH*IR_BITS-1:0]  CH_CODES    = {5'h17, 5'h11, 5'h10, 5'h01},
    parameter logic [IR_BITS-1:0]         RESET_INSTR = 5'h01
) (
    input  logic               TCK,
    input  logic               TRST,
    input  logic               TDI,
    input  logic               Test_Logic_Reset,
    input  logic               Capture_IR,
    input  logic               Shift_IR,
    input  logic               Update_IR,
    input  logic               Capture_DR,
    input  logic               Shift_DR,
    input  logic [NUM_CH-1:0]  dr_shift_in,
    output logic [IR_BITS-1:0] instr_out,
    output logic [NUM_CH-1:0]  dr_sel,
    output logic               bypass_sel,
    output logic               TDO,
    output logic               tdo_en
);

    localparam logic [IR_BITS-1:0] ALL_ONES   = {IR_BITS{1'b1}};
    // Capture pattern: the mandatory 2'b01 in the two LSBs, zeros above.
    localparam logic [IR_BITS-1:0] IR_CAPTURE = {{(IR_BITS-2){1'b0}}, 2'b01};

    logic [IR_BITS-1:0] r_ir_sr;
    logic [IR_BITS-1:0] r_instr;
    logic               r_bypass;
    logic               r_tdo;
    logic               r_tdo_en;

    logic [NUM_CH-1:0]  w_dr_sel;
    logic               w_hit;
    logic               w_dr_bit;

    // IR shift register: capture has priority over shift, LSB leaves first.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            r_ir_sr <= IR_CAPTURE;
        end else if (Capture_IR) begin
            r_ir_sr <= IR_CAPTURE;
        end else if (Shift_IR) begin
            r_ir_sr <= {TDI, r_ir_sr[IR_BITS-1:1]};
        end else begin
            r_ir_sr <= r_ir_sr;
        end
    end

    // IR update register: Test-Logic-Reset overrides a simultaneous update.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            r_instr <= RESET_INSTR;
        end else if (Test_Logic_Reset) begin
            r_instr <= RESET_INSTR;
        end else if (Update_IR) begin
            r_instr <= r_ir_sr;
        end else begin
            r_instr <= r_instr;
        end
    end

    // Channel decode: lowest matching index wins; all-ones always means BYPASS,
    // so table entries that are all-ones can never be selected.
    always_comb begin
        w_dr_sel = '0;
        w_hit    = 1'b0;
        if (r_instr != ALL_ONES) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!w_hit &&
                    (CH_CODES[i*IR_BITS +: IR_BITS] == r_instr) &&
                    (CH_CODES[i*IR_BITS +: IR_BITS] != ALL_ONES)) begin
                    w_dr_sel[i] = 1'b1;
                    w_hit       = 1'b1;
                end else begin
                    w_dr_sel[i] = w_dr_sel[i];
                end
            end
        end else begin
            w_hit = 1'b0;
        end
    end

    // BYPASS register, only clocked while it is the selected data register.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            r_bypass <= 1'b0;
        end else if (!w_hit && Capture_DR) begin
            r_bypass <= 1'b0;
        end else if (!w_hit && Shift_DR) begin
            r_bypass <= TDI;
        end else begin
            r_bypass <= r_bypass;
        end
    end

    // Serial bit of the selected data register.
    assign w_dr_bit = w_hit ? (|(dr_shift_in & w_dr_sel)) : r_bypass;

    // TDO retiming: IR path wins if both shift strobes are (illegally) high.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            r_tdo <= 1'b0;
        end else if (Shift_IR) begin
            r_tdo <= r_ir_sr[0];
        end else if (Shift_DR) begin
            r_tdo <= w_dr_bit;
        end else begin
            r_tdo <= r_tdo;
        end
    end

    // Output enable, aligned with the TDO update edge.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            r_tdo_en <= 1'b0;
        end else begin
            r_tdo_en <= Shift_IR | Shift_DR;
        end
    end

    assign instr_out  = r_instr;
    assign dr_sel     = w_dr_sel;
    assign bypass_sel = ~w_hit;
    assign TDO        = r_tdo;
    assign tdo_en     = r_tdo_en;

endmodule

// File: tb/tb_jtag_ir_dr_mux.sv
`timescale 1ns/1ps
module tb_jtag_ir_dr_mux;

    logic       TCK = 1'b0;
    logic       TRST;
    logic       TDI;
    logic       Test_Logic_Reset;
    logic       Capture_IR;
    logic       Shift_IR;
    logic       Update_IR;
    logic       Capture_DR;
    logic       Shift_DR;
    logic [3:0] dr_shift_in;
    logic [4:0] instr_out;
    logic [3:0] dr_sel;
    logic       bypass_sel;
    logic       TDO;
    logic       tdo_en;

    int checks = 0;
    int fails  = 0;

    jtag_ir_dr_mux dut (
        .TCK              (TCK),
        .TRST             (TRST),
        .TDI              (TDI),
        .Test_Logic_Reset (Test_Logic_Reset),
        .Capture_IR       (Capture_IR),
        .Shift_IR         (Shift_IR),
        .Update_IR        (Update_IR),
        .Capture_DR       (Capture_DR),
        .Shift_DR         (Shift_DR),
        .dr_shift_in      (dr_shift_in),
        .instr_out        (instr_out),
        .dr_sel           (dr_sel),
        .bypass_sel       (bypass_sel),
        .TDO              (TDO),
        .tdo_en           (tdo_en)
    );

    always #5 TCK = ~TCK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic tlr, input logic cir, input logic sir,
                         input logic uir, input logic cdr, input logic sdr,
                         input logic tdi);
        Test_Logic_Reset = tlr;
        Capture_IR       = cir;
        Shift_IR         = sir;
        Update_IR        = uir;
        Capture_DR       = cdr;
        Shift_DR         = sdr;
        TDI              = tdi;
    endtask

    task automatic at_neg();
        @(negedge TCK);
        #1;
    endtask

    task automatic at_pos();
        @(posedge TCK);
        #1;
    endtask

    task automatic load_ir(input logic [4:0] v);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        at_neg(); at_pos();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, v[k]);
            at_neg(); at_pos();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        at_neg(); at_pos();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        TRST = 1'b0;
        dr_shift_in = 4'b0000;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge TCK);
        #1;
        checks++; if (instr_out !== 5'h01) begin fails++; $display("FAIL reset_instr: got %h want 01", instr_out); end
        checks++; if (dr_sel !== 4'b0001) begin fails++; $display("FAIL reset_dr_sel: got %b want 0001", dr_sel); end
        checks++; if (bypass_sel !== 1'b0) begin fails++; $display("FAIL reset_bypass_sel: got %b want 0", bypass_sel); end
        checks++; if (TDO !== 1'b0) begin fails++; $display("FAIL reset_tdo: got %b want 0", TDO); end
        checks++; if (tdo_en !== 1'b0) begin fails++; $display("FAIL reset_tdo_en: got %b want 0", tdo_en); end
        TRST = 1'b1;
    endtask

    task automatic test_ir_scan();
        logic [4:0] bits;
        logic [4:0] exp_tdo;
        bits    = 5'b10001;
        exp_tdo = 5'b00001;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        at_neg(); at_pos();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, bits[k]);
            at_neg();
            checks++; if (TDO !== exp_tdo[k]) begin fails++; $display("FAIL ir_scan_tdo[%0d]: got %b want %b", k, TDO, exp_tdo[k]); end
            checks++; if (tdo_en !== 1'b1) begin fails++; $display("FAIL ir_scan_tdo_en[%0d]: got %b want 1", k, tdo_en); end
            at_pos();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        at_neg();
        checks++; if (instr_out !== 5'h11) begin fails++; $display("FAIL ir_scan_instr: got %h want 11", instr_out); end
        checks++; if (dr_sel !== 4'b0100) begin fails++; $display("FAIL ir_scan_dr_sel: got %b want 0100", dr_sel); end
        checks++; if (bypass_sel !== 1'b0) begin fails++; $display("FAIL ir_scan_bypass_sel: got %b want 0", bypass_sel); end
        checks++; if (tdo_en !== 1'b0) begin fails++; $display("FAIL ir_scan_tdo_en_off: got %b want 0", tdo_en); end
        at_pos();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_bypass();
        logic [3:0] tdi_seq;
        logic [3:0] exp_tdo;
        tdi_seq = 4'b1101;   // TDI order 1,0,1,1 (index 0 first)
        exp_tdo = 4'b1010;   // TDO order 0,1,0,1
        load_ir(5'h1F);
        checks++; if (bypass_sel !== 1'b1) begin fails++; $display("FAIL bypass_sel_1f: got %b want 1", bypass_sel); end
        checks++; if (dr_sel !== 4'b0000) begin fails++; $display("FAIL bypass_dr_sel_1f: got %b want 0000", dr_sel); end
        // Preload BYPASS with 1 so the capture clearing it is observable.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        at_neg(); at_pos();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        at_neg(); at_pos();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tdi_seq[k]);
            at_neg();
            checks++; if (TDO !== exp_tdo[k]) begin fails++; $display("FAIL bypass_tdo[%0d]: got %b want %b", k, TDO, exp_tdo[k]); end
            at_pos();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_decode();
        load_ir(5'h05);
        checks++; if (bypass_sel !== 1'b1) begin fails++; $display("FAIL unmatched_bypass_sel: got %b want 1", bypass_sel); end
        checks++; if (dr_sel !== 4'b0000) begin fails++; $display("FAIL unmatched_dr_sel: got %b want 0000", dr_sel); end
        load_ir(5'h10);
        checks++; if (instr_out !== 5'h10) begin fails++; $display("FAIL ch1_instr: got %h want 10", instr_out); end
        checks++; if (dr_sel !== 4'b0010) begin fails++; $display("FAIL ch1_dr_sel: got %b want 0010", dr_sel); end
        checks++; if (bypass_sel !== 1'b0) begin fails++; $display("FAIL ch1_bypass_sel: got %b want 0", bypass_sel); end
        // Shift_DR: TDO follows dr_shift_in[1] only.
        dr_shift_in = 4'b0010;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        at_neg();
        checks++; if (TDO !== 1'b1) begin fails++; $display("FAIL ch1_tdo_a: got %b want 1", TDO); end
        at_pos();
        dr_shift_in = 4'b1101;
        at_neg();
        checks++; if (TDO !== 1'b0) begin fails++; $display("FAIL ch1_tdo_b: got %b want 0", TDO); end
        at_pos();
        // Not shifting: TDO holds.
        dr_shift_in = 4'b0010;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        at_neg();
        checks++; if (TDO !== 1'b0) begin fails++; $display("FAIL ch1_tdo_hold0: got %b want 0", TDO); end
        checks++; if (tdo_en !== 1'b0) begin fails++; $display("FAIL ch1_tdo_en_idle: got %b want 0", tdo_en); end
        at_pos();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        at_neg();
        checks++; if (TDO !== 1'b1) begin fails++; $display("FAIL ch1_tdo_c: got %b want 1", TDO); end
        at_pos();
        dr_shift_in = 4'b0000;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        at_neg();
        checks++; if (TDO !== 1'b1) begin fails++; $display("FAIL ch1_tdo_hold1: got %b want 1", TDO); end
        at_pos();
        // Both shift strobes high: IR bit (1 after capture) beats DR bit (0).
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        at_neg(); at_pos();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        at_neg();
        checks++; if (TDO !== 1'b1) begin fails++; $display("FAIL illegal_ir_wins: got %b want 1", TDO); end
        at_pos();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_tlr();
        load_ir(5'h11);
        checks++; if (instr_out !== 5'h11) begin fails++; $display("FAIL tlr_pre_instr: got %h want 11", instr_out); end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        at_neg();
        checks++; if (instr_out !== 5'h01) begin fails++; $display("FAIL tlr_instr: got %h want 01", instr_out); end
        checks++; if (dr_sel !== 4'b0001) begin fails++; $display("FAIL tlr_dr_sel: got %b want 0001", dr_sel); end
        at_pos();
        // IR shift register untouched by Test-Logic-Reset.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        at_neg();
        checks++; if (instr_out !== 5'h11) begin fails++; $display("FAIL tlr_ir_sr_kept: got %h want 11", instr_out); end
        at_pos();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_trst_abort();
        logic [4:0] bits;
        bits = 5'h10;
        load_ir(5'h11);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        at_neg(); at_pos();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, bits[k]);
            at_neg(); at_pos();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, bits[2]);
        at_neg();
        TRST = 1'b0;
        #1;
        checks++; if (instr_out !== 5'h01) begin fails++; $display("FAIL abort_instr: got %h want 01", instr_out); end
        checks++; if (dr_sel !== 4'b0001) begin fails++; $display("FAIL abort_dr_sel: got %b want 0001", dr_sel); end
        checks++; if (bypass_sel !== 1'b0) begin fails++; $display("FAIL abort_bypass_sel: got %b want 0", bypass_sel); end
        checks++; if (TDO !== 1'b0) begin fails++; $display("FAIL abort_tdo: got %b want 0", TDO); end
        checks++; if (tdo_en !== 1'b0) begin fails++; $display("FAIL abort_tdo_en: got %b want 0", tdo_en); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        at_pos();
        TRST = 1'b1;
        // IR shift register was reset too: an update now yields the capture value.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        at_neg();
        checks++; if (instr_out !== 5'h01) begin fails++; $display("FAIL abort_ir_sr: got %h want 01", instr_out); end
        at_pos();
        load_ir(5'h10);
        checks++; if (instr_out !== 5'h10) begin fails++; $display("FAIL rescan_instr: got %h want 10", instr_out); end
        checks++; if (dr_sel !== 4'b0010) begin fails++; $display("FAIL rescan_dr_sel: got %b want 0010", dr_sel); end
    endtask

    initial begin
        test_reset();
        at_pos();
        test_ir_scan();
        test_bypass();
        test_decode();
        test_tlr();
        test_trst_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
